// File: rtl/pavana_slave_pkg.sv
// Shared types and constants for the out-of-order memory slave.
// The pending-read entry carries a wide tid field so any port TID_W up to TID_W_MAX fits.
package pavana_slave_pkg;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

   localparam int TID_W_DEF    = 2;
   localparam int TID_W_MAX    = 8;
   localparam int LAT_BASE_DEF = 2;
   localparam int LAT_STEP_DEF = 3;
   localparam int CNT_W        = 8;

   typedef struct packed {
      logic                 valid;
      logic [TID_W_MAX-1:0] tid;
      logic [31:0]          data;
      logic [CNT_W-1:0]     cnt;
   } pend_ent_t;

   // Read latency grows with addr[3:2] so neighbouring words return out of order.
   function automatic logic [CNT_W-1:0] rd_latency(input int base, input int step,
                                                   input logic [1:0] sel);
      int lat;
      lat = base + int'(sel) * step;
      return CNT_W'(lat);
   endfunction

endpackage

// File: rtl/pavana_ooo_rsp_arb.sv
// Fixed-priority response picker: the lowest-index ready entry is granted.
module pavana_ooo_rsp_arb #(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0] ready,
   output logic [DEPTH-1:0] gnt,
   output logic             gnt_valid
);

   logic found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && !found) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
      gnt_valid = found;
   end

endmodule

// File: rtl/pavana_slave_ooo_mem.sv
// Memory slave for one crossbar slave port: writes land immediately, reads are parked
// with an address-dependent latency and returned tagged, possibly out of order.
module pavana_slave_ooo_mem
   import pavana_slave_pkg::*;
#(
   parameter int MEM_AW   = 10,
   parameter int DEPTH    = 4,
   parameter int TID_W    = TID_W_DEF,
   parameter int LAT_BASE = LAT_BASE_DEF,
   parameter int LAT_STEP = LAT_STEP_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic [31:0]      addr_i,
   input  logic             cmd_i,
   input  logic [TID_W-1:0] reqtid_i,
   input  logic [31:0]      wdata_i,
   output logic             ack_o,
   output logic [TID_W-1:0] resptid_o,
   output logic [31:0]      rdata_o,
   output logic             resp_o
);

   logic [31:0]       mem [2**MEM_AW];
   pend_ent_t         ent [DEPTH];
   pend_ent_t         sel_ent;
   logic [MEM_AW-1:0] word_idx;
   logic [31:0]       rd_word;
   logic [CNT_W-1:0]  rd_lat;
   logic [DEPTH-1:0]  vld_vec;
   logic [DEPTH-1:0]  ready;
   logic [DEPTH-1:0]  gnt;
   logic [DEPTH-1:0]  free_oh;
   logic              gnt_valid;
   logic              full;
   logic              free_found;
   logic              rd_acc;
   logic              wr_acc;
   logic              unused_addr;
   logic [DEPTH-1:0]  unused_tid;

   assign word_idx    = addr_i[MEM_AW+1:2];
   assign rd_word     = mem[word_idx];
   assign rd_lat      = rd_latency(LAT_BASE, LAT_STEP, addr_i[3:2]);
   assign unused_addr = ^{addr_i[31:MEM_AW+2], addr_i[1:0]};

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         vld_vec[i]    = ent[i].valid;
         ready[i]      = ent[i].valid && (ent[i].cnt == '0);
         unused_tid[i] = ^ent[i].tid;
      end
   end

   // Full is taken from the current registers, so a slot retiring this edge is not reusable yet.
   assign full   = &vld_vec;
   assign ack_o  = req_i & ~rst_i & ((cmd_i == CMD_WR) | ~full);
   assign rd_acc = ack_o & (cmd_i == CMD_RD);
   assign wr_acc = ack_o & (cmd_i == CMD_WR);

   always_comb begin
      free_oh    = '0;
      free_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!vld_vec[i] && !free_found) begin
            free_oh[i] = 1'b1;
            free_found = 1'b1;
         end
      end
   end

   pavana_ooo_rsp_arb #(.DEPTH(DEPTH)) u_rsp_arb (
      .ready     (ready),
      .gnt       (gnt),
      .gnt_valid (gnt_valid)
   );

   always_comb begin
      sel_ent = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (gnt[i]) sel_ent = ent[i];
      end
   end

   // Contents survive reset, so the array sits outside the reset domain.
   always_ff @(posedge clk_i) begin
      if (wr_acc) mem[word_idx] <= wdata_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         resp_o    <= 1'b0;
         resptid_o <= '0;
         rdata_o   <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (gnt[i]) begin
               ent[i].valid <= 1'b0;
            end else if (ent[i].valid && (ent[i].cnt != '0)) begin
               ent[i].cnt <= ent[i].cnt - CNT_W'(1);
            end
            if (rd_acc && free_oh[i]) begin
               ent[i] <= '{valid: 1'b1, tid: TID_W_MAX'(reqtid_i), data: rd_word, cnt: rd_lat};
            end
         end
         resp_o <= gnt_valid;
         if (gnt_valid) begin
            resptid_o <= sel_ent.tid[TID_W-1:0];
            rdata_o   <= sel_ent.data;
         end
      end
   end

endmodule

// File: tb/tb_pavana_slave_ooo_mem.sv
// Scoreboard bench for pavana_slave_ooo_mem: reads push expected tid/data/earliest cycle,
// the response monitor pops by tid and checks data and timing.
module tb_pavana_slave_ooo_mem;

   localparam int TID_W = 2;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             req_i;
   logic [31:0]      addr_i;
   logic             cmd_i;
   logic [TID_W-1:0] reqtid_i;
   logic [31:0]      wdata_i;
   logic             ack_o;
   logic [TID_W-1:0] resptid_o;
   logic [31:0]      rdata_o;
   logic             resp_o;

   always #5 clk_i = ~clk_i;

   pavana_slave_ooo_mem dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_i),
      .addr_i    (addr_i),
      .cmd_i     (cmd_i),
      .reqtid_i  (reqtid_i),
      .wdata_i   (wdata_i),
      .ack_o     (ack_o),
      .resptid_o (resptid_o),
      .rdata_o   (rdata_o),
      .resp_o    (resp_o)
   );

   typedef struct {
      logic [TID_W-1:0] tid;
      logic [31:0]      data;
      int               min_cyc;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] model [int];
   int          rsp_tid_log [$];
   int          rsp_cyc_log [$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;

   always @(posedge clk_i) cyc = cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int lat_of(input logic [31:0] a);
      return 2 + 3 * int'(a[3:2]);
   endfunction

   always @(negedge clk_i) begin
      int idx;
      if (resp_o === 1'b1) begin
         idx = -1;
         for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].tid == resptid_o) begin
               idx = i;
               break;
            end
         end
         check_eq("resp_expected", 32'(idx >= 0), 32'd1);
         if (idx >= 0) begin
            check_eq("resp_data", rdata_o, sb[idx].data);
            check_eq("resp_not_early", 32'(cyc >= sb[idx].min_cyc), 32'd1);
            sb.delete(idx);
         end
         rsp_tid_log.push_back(int'(resptid_o));
         rsp_cyc_log.push_back(cyc);
      end
   end

   task automatic clear_logs();
      rsp_tid_log.delete();
      rsp_cyc_log.delete();
   endtask

   task automatic idle(input int n);
      req_i = 1'b0;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      req_i = 1'b1; cmd_i = 1'b1; addr_i = a; wdata_i = d;
      @(negedge clk_i);
      check_eq("wr_ack", 32'(ack_o), 32'd1);
      @(posedge clk_i); #1;
      model[int'(a[11:2])] = d;
      req_i = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [TID_W-1:0] t, output int e0);
      int          n;
      logic [31:0] d;
      n  = 0;
      e0 = -1;
      req_i = 1'b1; cmd_i = 1'b0; addr_i = a; reqtid_i = t;
      while (e0 < 0 && n < 100) begin
         @(negedge clk_i);
         if (ack_o === 1'b1) begin
            d = model[int'(a[11:2])];
            @(posedge clk_i); #1;
            e0 = cyc;
            sb.push_back('{t, d, e0 + lat_of(a) + 1});
         end else begin
            @(posedge clk_i); #1;
         end
         n++;
      end
      req_i = 1'b0;
      check_eq("rd_acked", 32'(e0 >= 0), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk_i); #1;
         n++;
      end
      check_eq("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int e [5];
      int ea;
      rst_i = 1'b1; req_i = 1'b1; cmd_i = 1'b1; addr_i = 32'h10;
      wdata_i = 32'h0BAD_0BAD; reqtid_i = '0;
      repeat (3) @(posedge clk_i); #1;
      check_eq("rst_ack", 32'(ack_o), 32'd0);
      check_eq("rst_resp", 32'(resp_o), 32'd0);
      check_eq("rst_rdata", rdata_o, 32'd0);
      check_eq("rst_resptid", 32'(resptid_o), 32'd0);
      req_i = 1'b0;
      rst_i = 1'b0;
      idle(1);

      // basic write then read, exact latency and single-cycle pulse
      wr(32'h10, 32'hDEAD_BEEF);
      clear_logs();
      rd(32'h10, 2'd1, e[0]);
      drain();
      check_eq("t1_resp_cycle", 32'(rsp_cyc_log[0]), 32'(e[0] + 3));
      check_eq("t1_resp_tid", 32'(rsp_tid_log[0]), 32'd1);
      @(negedge clk_i);
      check_eq("t1_pulse_width", 32'(resp_o), 32'd0);
      idle(1);

      // long then short read: out-of-order return
      wr(32'h0C, 32'h1111_1111);
      wr(32'h00, 32'h2222_2222);
      clear_logs();
      rd(32'h0C, 2'd0, e[0]);
      rd(32'h00, 2'd2, e[1]);
      drain();
      check_eq("t2_count", 32'(rsp_tid_log.size()), 32'd2);
      check_eq("t2_first_tid", 32'(rsp_tid_log[0]), 32'd2);
      check_eq("t2_second_tid", 32'(rsp_tid_log[1]), 32'd0);
      check_eq("t2_short_cycle", 32'(rsp_cyc_log[0]), 32'(e[1] + 3));
      check_eq("t2_long_cycle", 32'(rsp_cyc_log[1]), 32'(e[0] + 12));
      idle(2);

      // five reads against a four-deep buffer
      clear_logs();
      for (int i = 0; i < 5; i++) rd(32'h0C, 2'(i % 4), e[i]);
      check_eq("t3_b2b_accept", 32'(e[3]), 32'(e[0] + 3));
      check_eq("t3_fifth_accept", 32'(e[4]), 32'(e[0] + 13));
      check_eq("t3_fifth_after_first_rsp", 32'(e[4]), 32'(rsp_cyc_log[0] + 1));
      drain();
      check_eq("t3_count", 32'(rsp_tid_log.size()), 32'd5);
      idle(2);

      // equal latency, older read parked in the higher index
      wr(32'h04, 32'h0404_0404);
      clear_logs();
      rd(32'h04, 2'd0, ea);
      idle(2);
      rd(32'h04, 2'd1, e[1]);
      idle(2);
      rd(32'h00, 2'd2, e[2]);
      rd(32'h00, 2'd3, e[3]);
      check_eq("t4_accept_p", 32'(e[2]), 32'(ea + 6));
      check_eq("t4_accept_q", 32'(e[3]), 32'(ea + 7));
      drain();
      check_eq("t4_count", 32'(rsp_tid_log.size()), 32'd4);
      check_eq("t4_third_tid", 32'(rsp_tid_log[2]), 32'd3);
      check_eq("t4_fourth_tid", 32'(rsp_tid_log[3]), 32'd2);
      check_eq("t4_q_cycle", 32'(rsp_cyc_log[2]), 32'(ea + 10));
      check_eq("t4_p_cycle", 32'(rsp_cyc_log[3]), 32'(ea + 11));
      idle(2);

      // data captured at accept, later write seen by later read
      wr(32'h20, 32'hA5A5_A5A5);
      clear_logs();
      rd(32'h20, 2'd1, e[0]);
      wr(32'h20, 32'h0000_0055);
      drain();
      rd(32'h20, 2'd2, e[1]);
      drain();
      check_eq("t5_count", 32'(rsp_tid_log.size()), 32'd2);
      idle(2);

      // reset with reads pending and a pulse on the wire
      clear_logs();
      rd(32'h00, 2'd0, e[0]);
      rd(32'h0C, 2'd1, e[1]);
      rd(32'h0C, 2'd2, e[2]);
      rd(32'h08, 2'd3, e[3]);
      @(negedge clk_i);
      check_eq("t6_pulse_live", 32'(resp_o), 32'd1);
      #1;
      rst_i = 1'b1; req_i = 1'b1; cmd_i = 1'b0; addr_i = 32'h0;
      #1;
      check_eq("t6_resp_cut", 32'(resp_o), 32'd0);
      check_eq("t6_ack_in_rst", 32'(ack_o), 32'd0);
      sb.delete();
      repeat (3) @(posedge clk_i); #1;
      req_i = 1'b0;
      rst_i = 1'b0;
      clear_logs();
      repeat (30) @(posedge clk_i); #1;
      check_eq("t6_no_stale_resp", 32'(rsp_tid_log.size()), 32'd0);
      rd(32'h10, 2'd1, e[0]);
      rd(32'h0C, 2'd3, e[1]);
      drain();
      check_eq("t6_post_rst_count", 32'(rsp_tid_log.size()), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout cycle=%0d limit reached", cyc);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pavana_slave_ooo_mem.md
Name: pavana_slave_ooo_mem

Overview:
- Memory slave endpoint that attaches directly to one slave_N port of the 4-master/4-slave out-of-order crossbar and consumes its requests.
- Accepts tagged read/write requests and performs writes immediately.
- Parks each read in a small tagged buffer with an address-dependent latency, then returns read responses out of order, tagged with the originating transaction ID.
- Serves as the synthesisable/simulation target that exercises the crossbar's reqtid/resptid reordering.

Parameters:
- MEM_AW, 10, word-index width; memory holds 2^MEM_AW 32-bit words, indexed by addr_i[MEM_AW+1:2].
- DEPTH, 4, read-pending buffer entries (2..8).
- TID_W, 2, transaction ID width; must match the crossbar slave port.
- LAT_BASE, 2, base read latency in cycles (>=1).
- LAT_STEP, 3, extra latency per addr_i[3:2] step.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  request valid.
- addr_i  in  32  byte address; bits [1:0] ignored.
- cmd_i  in  1  0 = read, 1 = write.
- reqtid_i  in  TID_W  transaction ID of the request.
- wdata_i  in  32  write data.
- ack_o  out  1  request accepted this cycle (combinational).
- resptid_o  out  TID_W  ID of the returned read.
- rdata_o  out  32  read data.
- resp_o  out  1  read response valid, single-cycle pulse; no backpressure.

Behaviour:
- Reset (async assert): all buffer valid bits, resp_o, resptid_o and rdata_o clear to 0. ack_o is forced 0 while rst_i is high. Memory contents are not reset and are retained across reset.
- Acceptance is defined as req_i & ack_o at a rising edge.
- Writes: ack_o = req_i & cmd_i & ~rst_i, i.e. writes are always accepted. mem[addr_i[MEM_AW+1:2]] <= wdata_i at the accept edge. No response is generated for writes.
- Reads: ack_o = req_i & ~cmd_i & ~full & ~rst_i.
  - full means all DEPTH entries are valid, sampled from current registers. A slot freed at an edge is visible only in the following cycle; there is no same-cycle bypass.
  - At the accept edge, the lowest-index free entry is loaded with: valid = 1, tid = reqtid_i, data = mem[addr] (read at accept, so later writes do not affect it), cnt = L.
  - L = LAT_BASE + addr_i[3:2] * LAT_STEP; cnt is 8 bits wide.
- Countdown: at each edge, every valid entry with cnt > 0 decrements. An entry with cnt == 0 is ready.
- Response select: among ready entries, the lowest index wins (sub-module). At the next edge: resp_o <= 1, resptid_o <= entry.tid, rdata_o <= entry.data, and that entry's valid clears. With no ready entry, resp_o <= 0; rdata_o and resptid_o hold.
- Latency: a read accepted at edge E0 with no contention produces resp_o high in the cycle following edge E0+L+1. Losing ready entries hold cnt = 0 and wait.
- At most one response per cycle, and resp_o is never high two cycles for the same entry.
- Simultaneous read retire and new read accept in one edge is legal. The freed slot is not reused in that edge; the new entry takes a different free slot.
- Ordering: responses follow latency, not arrival order. Equal-latency reads return in index order, not strictly in acceptance order.
- Read-after-write to the same address, with the read accepted at a later edge than the write, returns the written data. The same-edge case cannot occur: single request port.
- Reset mid-operation: all pending reads are discarded with no response, and any in-flight resp_o pulse is cut.

Decomposition:
- Package pavana_slave_pkg:
  - CMD_RD = 1'b0, CMD_WR = 1'b1.
  - TID_W default.
  - Pending-entry struct {valid, tid, data[31:0], cnt[7:0]}.
  - Latency-function constants.
- Sub-module pavana_ooo_rsp_arb: DEPTH-bit ready vector in, one-hot grant plus valid out; fixed lowest-index priority; combinational.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10 (addr[3:2]=0), then read 0x10 with tid 1 -> write ack same cycle; read acked; resp_o high L+1=3 cycles after the accept edge with rdata 0xDEADBEEF, resptid 1, for exactly 1 cycle.
- Write 0x11111111 @0x0C and 0x22222222 @0x00; read 0x0C (tid 0, L=11), then read 0x00 on the next cycle (tid 2, L=2) -> tid 2 / 0x22222222 returns first, tid 0 / 0x11111111 returns later (out of order).
- Issue 5 back-to-back reads at 0x0C, tids 0..3,0, DEPTH=4 -> first 4 acked, 5th sees ack_o=0 until the cycle after the first response edge, then is acked; all 5 responses are delivered.
- Two reads at the same latency accepted in consecutive cycles, with the buffer arranged so the older one sits in the higher index -> the lower-index entry responds first; responses go out on consecutive cycles, never overlapped.
- Read 0x20 accepted, then write 0x55 to 0x20 on the next cycle -> response returns the old value captured at accept; a subsequent read returns 0x55.
- Assert rst_i with 3 reads pending and a pulse in progress -> resp_o drops immediately, no responses after release, ack_o=0 during reset; memory data written before reset still reads back correctly.
